pipelined_barrel_shifter: RTL and testbench



---
 rtl/pipelined_barrel_shifter.sv | 153 +++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_barrel_shifter
// Brief    : SLL/SRL/SRA/ROR barrel shifter, one level per stage, global-stall
//            valid/ready flow. Optional sticky output under macro STICKY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef STICKY_EN
    output logic             out_sticky,
`endif
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] c_OP_SLL = 2'b00;
    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;
    localparam logic [1:0] c_OP_ROR = 2'b11;

    function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // Every level shifts toward the LSB; only the fill of the vacated MSBs differs.
    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d,
                                                 input int               sh,
                                                 input logic [1:0]       op,
                                                 input logic             sign);
        logic [WIDTH-1:0] hi_mask;
        logic [WIDTH-1:0] r;
        hi_mask = ~({WIDTH{1'b1}} >> sh);
        case (op)
            c_OP_ROR: r = (d >> sh) | (d << (WIDTH - sh));
            c_OP_SRA: r = (d >> sh) | (sign ? hi_mask : '0);
            default:  r = d >> sh;
        endcase
        return r;
    endfunction

`ifdef STICKY_EN
    function automatic logic f_dropped(input logic [WIDTH-1:0] d, input int sh);
        return |(d & ~({WIDTH{1'b1}} << sh));
    endfunction
`endif

    logic [WIDTH-1:0] data_q  [0:SHW];
    logic [WIDTH-1:0] data_d  [0:SHW];
    logic [1:0]       op_q    [0:SHW];
    logic [1:0]       op_d    [0:SHW];
    logic             valid_q [0:SHW];
    logic             valid_d [0:SHW];
    logic [SHW-1:0]   amt_q   [0:SHW-1];
    logic [SHW-1:0]   amt_d   [0:SHW-1];
    logic             sign_q  [0:SHW-1];
    logic             sign_d  [0:SHW-1];
`ifdef STICKY_EN
    logic             stk_q   [0:SHW];
    logic             stk_d   [0:SHW];
`endif

    logic w_stall;

    assign out_valid = valid_q[SHW];
    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall & ~rst;
    // SLL runs as a right shift on the reversed operand, so undo it here.
    assign out_data  = (op_q[SHW] == c_OP_SLL) ? f_rev(data_q[SHW]) : data_q[SHW];
`ifdef STICKY_EN
    assign out_sticky = stk_q[SHW];
`endif

    always_comb begin
        data_d[0]  = (in_op == c_OP_SLL) ? f_rev(in_data) : in_data;
        op_d[0]    = in_op;
        valid_d[0] = in_valid & in_ready;
        amt_d[0]   = in_amt;
        sign_d[0]  = in_data[WIDTH-1];
        for (int k = 1; k < SHW; k++) begin
            amt_d[k]  = amt_q[k-1];
            sign_d[k] = sign_q[k-1];
        end
        for (int k = 1; k <= SHW; k++) begin
            op_d[k]    = op_q[k-1];
            valid_d[k] = valid_q[k-1];
            if (amt_q[k-1][SHW-k]) begin
                data_d[k] = f_shift(data_q[k-1], 1 << (SHW - k), op_q[k-1], sign_q[k-1]);
            end else begin
                data_d[k] = data_q[k-1];
            end
        end
    end

`ifdef STICKY_EN
    // Sticky only accumulates for SRL/SRA; other modes keep it at 0.
    always_comb begin
        stk_d[0] = 1'b0;
        for (int k = 1; k <= SHW; k++) begin
            stk_d[k] = stk_q[k-1] |
                       (amt_q[k-1][SHW-k] &
                        ((op_q[k-1] == c_OP_SRL) | (op_q[k-1] == c_OP_SRA)) &
                        f_dropped(data_q[k-1], 1 << (SHW - k)));
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= SHW; k++) begin
                data_q[k]  <= '0;
                op_q[k]    <= '0;
                valid_q[k] <= 1'b0;
`ifdef STICKY_EN
                stk_q[k]   <= 1'b0;
`endif
            end
            for (int k = 0; k < SHW; k++) begin
                amt_q[k]  <= '0;
                sign_q[k] <= 1'b0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k <= SHW; k++) begin
                data_q[k]  <= data_d[k];
                op_q[k]    <= op_d[k];
                valid_q[k] <= valid_d[k];
`ifdef STICKY_EN
                stk_q[k]   <= stk_d[k];
`endif
            end
            for (int k = 0; k < SHW; k++) begin
                amt_q[k]  <= amt_d[k];
                sign_q[k] <= sign_d[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_barrel_shifter
// Brief    : Directed self-checking bench for pipelined_barrel_shifter (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_amt = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
`ifdef STICKY_EN
    logic        out_sticky;
`endif

    pipelined_barrel_shifter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef STICKY_EN
        .out_sticky(out_sticky),
`endif
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          n_recv   = 0;
    logic        track    = 1'b1;
    logic [31:0] exp_d    = '0;
    logic        exp_s    = 1'b0;
    logic [31:0] exp_dq [$];
    logic        exp_sq [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_d(input logic [1:0] op, input logic [31:0] a, input logic [4:0] n);
        case (op)
            2'b00:   return a << n;
            2'b01:   return a >> n;
            2'b10:   return $unsigned($signed(a) >>> n);
            default: return (n == 0) ? a : ((a >> n) | (a << (6'd32 - {1'b0, n})));
        endcase
    endfunction

    function automatic logic model_s(input logic [1:0] op, input logic [31:0] a, input logic [4:0] n);
        logic [31:0] m;
        m = (32'h1 << n) - 32'h1;
        return (op == 2'b01 || op == 2'b10) ? |(a & m) : 1'b0;
    endfunction

    // Scoreboard: push on accept, pop and compare on transfer.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready && track) begin
            exp_dq.push_back(exp_d);
            exp_sq.push_back(exp_s);
        end
        if (out_valid && out_ready) begin
            if (exp_dq.size() == 0) begin
                check("unexpected_result", 64'(out_data), 64'hDEAD);
            end else begin
                check("data", 64'(out_data), 64'(exp_dq.pop_front()));
`ifdef STICKY_EN
                check("sticky", 64'(out_sticky), 64'(exp_sq.pop_front()));
`else
                void'(exp_sq.pop_front());
`endif
                n_recv++;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] n,
                        input logic [31:0] ed, input logic es);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = n;
        exp_d    = ed;
        exp_s    = es;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic check_latency(input string tag);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen ? 64'(cyc - acc_cyc) : 64'hFFFF, 64'd5);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_dq.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_dq.size()), 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] rd;
        logic [4:0]  rn;
        int          base;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Single SRL with latency measurement
        send(2'b01, 32'h8000_0001, 5'd4, 32'h0800_0000, 1'b1);
        check_latency("latency_srl");
        drain();

        // Directed vectors, back-to-back
        base = n_recv;
        send(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
        send(2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1);
        send(2'b00, 32'h0000_00FF, 5'd28, 32'hF000_0000, 1'b0);
        send(2'b00, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 1'b0);
        send(2'b01, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 1'b0);
        send(2'b10, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 1'b0);
        send(2'b11, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 1'b0);
        send(2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0);
        send(2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0);
        send(2'b00, 32'h1234_5678, 5'd4,  32'h2345_6780, 1'b0);
        send(2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000, 1'b0);
        send(2'b01, 32'h0000_000F, 5'd3,  32'h0000_0001, 1'b1);
        drain();
        check("directed_count", 64'(n_recv - base), 64'd12);

        // Backpressure: 8 random ops, 3-cycle stall once the first result is valid
        base = n_recv;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    rop = 2'($urandom_range(0, 3));
                    rd  = $urandom;
                    rn  = 5'($urandom_range(0, 31));
                    send(rop, rd, rn, model_d(rop, rd, rn), model_s(rop, rd, rn));
                end
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) check("bp_first_valid_timeout", 64'd0, 64'd1);
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 64'(in_ready), 64'd0);
                    check("bp_out_valid_held", 64'(out_valid), 64'd1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(n_recv - base), 64'd8);

        // Reset mid-flight: 3 ops in the pipeline are discarded
        track = 1'b0;
        send(2'b01, 32'hFFFF_0000, 5'd1, 32'h0, 1'b0);
        send(2'b00, 32'h0000_FFFF, 5'd2, 32'h0, 1'b0);
        send(2'b11, 32'h1234_5678, 5'd3, 32'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_after", 64'(in_ready), 64'd1);
        base = n_recv;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        track = 1'b1;
        send(2'b10, 32'h8000_0010, 5'd4, 32'hF800_0001, 1'b0);
        check_latency("latency_after_rst");
        drain();
        check("midrst_count", 64'(n_recv - base), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
